// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - UART receiver (8N1) feeding a byte FIFO with sticky error flags
// Define UART_RX_PARITY_EN to expect an even-parity bit between bit 7 and the stop bit.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 347,
    parameter int DEPTH        = 8
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_i,
    input  logic                   rx_i,
    output logic [7:0]             rd_data_o,
    output logic                   rd_valid_o,
    input  logic                   rd_ready_i,
    output logic [$clog2(DEPTH):0] fifo_level_o,
    output logic                   rx_busy_o,
    output logic                   frame_err_o,
    output logic                   overrun_o,
    output logic                   parity_err_o,
    input  logic                   err_clr_i
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   LVL_FULL = (PW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_t;

    state_t          state;
    logic            rx_meta;
    logic            rxs;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shift_q;
    logic [7:0]      mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    logic sample;
    logic stop_hit;
    logic push;
    logic pop;
    logic full;
    logic wr_en;
    logic frame_set;
    logic ovr_set;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            {rx_meta, rxs} <= 2'b11;
        end else begin
            {rx_meta, rxs} <= {rx_i, rx_meta};
        end
    end

    assign sample    = (cnt == CNT_LAST);
    assign stop_hit  = (state == STOP) && sample;
    assign push      = stop_hit && rxs;
    assign frame_set = stop_hit && !rxs;
    assign pop       = rd_valid_o && rd_ready_i;
    assign full      = (fifo_level_o == LVL_FULL);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
    assign wr_en     = push && (!full || pop);
    assign ovr_set   = push && full && !pop;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift_q   <= '0;
            rx_busy_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state     <= START;
                        cnt       <= '0;
                        rx_busy_o <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (rxs) begin
                            state     <= IDLE;
                            rx_busy_o <= 1'b0;
                        end else begin
                            state   <= DATA;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (sample) begin
                        cnt     <= '0;
                        shift_q <= {rxs, shift_q[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (sample) begin
                        cnt   <= '0;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (sample) begin
                        cnt <= '0;
                        if (rxs) begin
                            state     <= IDLE;
                            rx_busy_o <= 1'b0;
                        end else begin
                            state <= WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_IDLE: begin
                    // Hold off until the line returns high so a break cannot retrigger.
                    if (rxs) begin
                        state     <= IDLE;
                        rx_busy_o <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rx_busy_o <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= shift_q;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level_o <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, pop})
                2'b10:   fifo_level_o <= fifo_level_o + 1'b1;
                2'b01:   fifo_level_o <= fifo_level_o - 1'b1;
                default: fifo_level_o <= fifo_level_o;
            endcase
        end
    end

    assign rd_valid_o = (fifo_level_o != '0);
    assign rd_data_o  = rd_valid_o ? mem[rd_ptr] : 8'h00;

    // Set takes priority over clear so an event coinciding with err_clr_i is not lost.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            frame_err_o <= 1'b0;
            overrun_o   <= 1'b0;
        end else begin
            if (frame_set) begin
                frame_err_o <= 1'b1;
            end else if (err_clr_i) begin
                frame_err_o <= 1'b0;
            end
            if (ovr_set) begin
                overrun_o <= 1'b1;
            end else if (err_clr_i) begin
                overrun_o <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_set;
    assign par_set = (state == PARITY) && sample && (rxs != ^shift_q);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            parity_err_o <= 1'b0;
        end else if (par_set) begin
            parity_err_o <= 1'b1;
        end else if (err_clr_i) begin
            parity_err_o <= 1'b0;
        end
    end
`else
    assign parity_err_o = 1'b0;
`endif

endmodule
